// File: rtl/tetris_pkg.sv
// Shared board geometry, counter widths and line-clear scoring table.
package tetris_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int BOARD_COLS = 10;
  localparam int SCORE_W    = 20;
  localparam int LINES_W    = 16;

  localparam logic [SCORE_W-1:0] POINTS [5] = '{
    20'd0, 20'd40, 20'd100, 20'd300, 20'd1200
  };

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_MERGE,
    ACT_COLLAPSE
  } board_act_t;

  // Multipliers above four score as a four-row clear.
  function automatic logic [SCORE_W-1:0] points_for(input logic [2:0] mult);
    logic [SCORE_W-1:0] pts;
    case (mult)
      3'd0:    pts = POINTS[0];
      3'd1:    pts = POINTS[1];
      3'd2:    pts = POINTS[2];
      3'd3:    pts = POINTS[3];
      default: pts = POINTS[4];
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/board_datapath_row_collapse.sv
// Completed-row detection and single-row removal of the lowest completed row.
module row_collapse
  import tetris_pkg::*;
#(
  parameter int ROWS = BOARD_ROWS,
  parameter int COLS = BOARD_COLS
) (
  input  logic [ROWS*COLS-1:0] board,
  output logic [ROWS-1:0]      completed,
  output logic                 found,
  output logic [ROWS*COLS-1:0] collapsed
);

  int unsigned sel;

  always_comb begin
    completed = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      completed[r] = &board[r*COLS +: COLS];
    end
  end

  // Later iterations win, so sel ends on the highest-index (lowest on screen) full row.
  always_comb begin
    sel   = 0;
    found = 1'b0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (completed[r]) begin
        sel   = r;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    collapsed = board;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (r <= sel) begin
        if (r == 0) begin
          collapsed[r*COLS +: COLS] = '0;
        end else begin
          collapsed[r*COLS +: COLS] = board[(r-1)*COLS +: COLS];
        end
      end
    end
  end

endmodule

// File: rtl/board_datapath.sv
// Settled-cell board register with merge/clear commands, status flags and score/line counters.
module board_datapath
  import tetris_pkg::*;
#(
  parameter int ROWS = BOARD_ROWS,
  parameter int COLS = BOARD_COLS
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [ROWS*COLS-1:0] piece_mask,
  input  logic                 update_board_state,
  input  logic                 shift_down,
  input  logic                 add_score,
  input  logic [2:0]           score_multiplier,
  input  logic                 game_over,
  output logic [ROWS*COLS-1:0] board,
  output logic                 filled_under,
  output logic                 overflow,
  output logic [ROWS-1:0]      completed_lines,
  output logic [SCORE_W-1:0]   score,
  output logic [LINES_W-1:0]   lines_cleared
);

  localparam int CELLS = ROWS * COLS;

  logic             row_found;
  logic [CELLS-1:0] collapsed;
  logic [CELLS-1:0] piece_below;
  logic [CELLS-1:0] board_next;
  logic [LINES_W-1:0] lines_next;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
  board_act_t         act;

  row_collapse #(
    .ROWS(ROWS),
    .COLS(COLS)
  ) u_collapse (
    .board    (board),
    .completed(completed_lines),
    .found    (row_found),
    .collapsed(collapsed)
  );

  // Shifting left by one row width moves every piece cell one row down.
  assign piece_below  = piece_mask << COLS;
  assign filled_under = (|piece_mask[CELLS-1 -: COLS]) | (|(piece_below & board));
  assign overflow     = |board[COLS-1:0];

  always_comb begin
    act = ACT_HOLD;
    if (!game_over) begin
      if (update_board_state) begin
        act = ACT_MERGE;
      end else if (shift_down && row_found) begin
        act = ACT_COLLAPSE;
      end
    end
  end

  always_comb begin
    board_next = board;
    lines_next = lines_cleared;
    case (act)
      ACT_MERGE: board_next = board | piece_mask;
      ACT_COLLAPSE: begin
        board_next = collapsed;
        if (lines_cleared != '1) begin
          lines_next = lines_cleared + LINES_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    score_sum  = {1'b0, score} + {1'b0, points_for(score_multiplier)};
    score_next = score;
    if (add_score && !game_over) begin
      score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      board         <= '0;
      score         <= '0;
      lines_cleared <= '0;
    end else begin
      board         <= board_next;
      score         <= score_next;
      lines_cleared <= lines_next;
    end
  end

endmodule

// File: tb/tb_board_datapath.sv
// Self-checking bench for board_datapath: vector table through a scoreboard plus reset/status sequences.
module tb_board_datapath;

  localparam int R = 20;
  localparam int C = 10;
  localparam int N = R * C;

  logic          clock = 1'b0;
  logic          resetn;
  logic [N-1:0]  piece_mask;
  logic          update_board_state;
  logic          shift_down;
  logic          add_score;
  logic [2:0]    score_multiplier;
  logic          game_over;
  logic [N-1:0]  board;
  logic          filled_under;
  logic          overflow;
  logic [R-1:0]  completed_lines;
  logic [19:0]   score;
  logic [15:0]   lines_cleared;

  always #5 clock = ~clock;

  board_datapath #(.ROWS(R), .COLS(C)) dut (
    .clock             (clock),
    .resetn            (resetn),
    .piece_mask        (piece_mask),
    .update_board_state(update_board_state),
    .shift_down        (shift_down),
    .add_score         (add_score),
    .score_multiplier  (score_multiplier),
    .game_over         (game_over),
    .board             (board),
    .filled_under      (filled_under),
    .overflow          (overflow),
    .completed_lines   (completed_lines),
    .score             (score),
    .lines_cleared     (lines_cleared)
  );

  typedef struct {
    logic [N-1:0] piece;
    logic         upd;
    logic         sd;
    logic         add;
    logic [2:0]   mult;
    logic         go;
    int           exp_score;
    int           exp_lines;
    logic [R-1:0] exp_comp;
    logic         exp_ovf;
  } vec_t;

  typedef struct {
    logic [N-1:0] brd;
    int           score;
    int           lines;
    logic [R-1:0] comp;
    logic         ovf;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  vec_t tbl[17];
  logic [C-1:0] mb [R];

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] pc(input int r, input logic [C-1:0] cols);
    logic [N-1:0] p;
    p = '0;
    p[r*C +: C] = cols;
    return p;
  endfunction

  function automatic vec_t mk(input logic [N-1:0] p, input logic u, input logic s, input logic a,
                              input logic [2:0] m, input logic g, input int sc, input int ln,
                              input logic [R-1:0] cp, input logic ov);
    vec_t v;
    v.piece = p;  v.upd = u;  v.sd = s;  v.add = a;  v.mult = m;  v.go = g;
    v.exp_score = sc;  v.exp_lines = ln;  v.exp_comp = cp;  v.exp_ovf = ov;
    return v;
  endfunction

  function automatic logic [N-1:0] m_flat();
    logic [N-1:0] f;
    for (int r = 0; r < R; r++) f[r*C +: C] = mb[r];
    return f;
  endfunction

  function automatic logic m_fu(input logic [N-1:0] p);
    if (p[(R-1)*C +: C] != '0) return 1'b1;
    for (int r = 0; r < R - 1; r++) begin
      if ((p[r*C +: C] & mb[r+1]) != '0) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_step(input vec_t v);
    int k;
    if (!v.go) begin
      if (v.upd) begin
        for (int r = 0; r < R; r++) mb[r] = mb[r] | v.piece[r*C +: C];
      end else if (v.sd) begin
        k = -1;
        for (int r = 0; r < R; r++) if (mb[r] == '1) k = r;
        if (k >= 0) begin
          for (int r = k; r > 0; r--) mb[r] = mb[r-1];
          mb[0] = '0;
        end
      end
    end
  endtask

  task automatic drive_step(input string tag, input vec_t v);
    exp_t e;
    piece_mask         = v.piece;
    update_board_state = v.upd;
    shift_down         = v.sd;
    add_score          = v.add;
    score_multiplier   = v.mult;
    game_over          = v.go;
    model_step(v);
    e.brd = m_flat();  e.score = v.exp_score;  e.lines = v.exp_lines;
    e.comp = v.exp_comp;  e.ovf = v.exp_ovf;
    sb.push_back(e);
    @(posedge clock);
    #1;
    update_board_state = 1'b0;
    shift_down         = 1'b0;
    add_score          = 1'b0;
    game_over          = 1'b0;
    e = sb.pop_front();
    check({tag, " board"}, board, e.brd);
    check({tag, " score"}, N'(score), N'(e.score));
    check({tag, " lines"}, N'(lines_cleared), N'(e.lines));
    check({tag, " completed"}, N'(completed_lines), N'(e.comp));
    check({tag, " overflow"}, N'(overflow), N'(e.ovf));
  endtask

  initial begin
    int cur;
    vec_t v;

    tbl[0]  = mk(pc(19, 10'h00F), 1, 0, 0, 3'd0, 0,    0, 0, 20'h00000, 0);
    tbl[1]  = mk(pc(19, 10'h3F0), 1, 0, 0, 3'd0, 0,    0, 0, 20'h80000, 0);
    tbl[2]  = mk(pc(18, 10'h3FF), 1, 0, 0, 3'd0, 0,    0, 0, 20'hC0000, 0);
    tbl[3]  = mk(pc(17, 10'h020), 1, 0, 0, 3'd0, 0,    0, 0, 20'hC0000, 0);
    tbl[4]  = mk('0,              0, 1, 0, 3'd0, 0,    0, 1, 20'h80000, 0);
    tbl[5]  = mk('0,              0, 1, 0, 3'd0, 0,    0, 2, 20'h00000, 0);
    tbl[6]  = mk('0,              0, 1, 0, 3'd0, 0,    0, 2, 20'h00000, 0);
    tbl[7]  = mk('0,              0, 0, 1, 3'd4, 0, 1200, 2, 20'h00000, 0);
    tbl[8]  = mk('0,              0, 0, 1, 3'd7, 0, 2400, 2, 20'h00000, 0);
    tbl[9]  = mk(pc(0, 10'h001),  1, 0, 1, 3'd1, 0, 2440, 2, 20'h00000, 1);
    tbl[10] = mk('0,              0, 0, 1, 3'd2, 0, 2540, 2, 20'h00000, 1);
    tbl[11] = mk('0,              0, 0, 1, 3'd3, 0, 2840, 2, 20'h00000, 1);
    tbl[12] = mk('0,              0, 0, 1, 3'd0, 0, 2840, 2, 20'h00000, 1);
    tbl[13] = mk(pc(19, 10'h3DF), 1, 0, 0, 3'd0, 0, 2840, 2, 20'h80000, 1);
    tbl[14] = mk(pc(10, 10'h001), 1, 1, 0, 3'd0, 0, 2840, 2, 20'h80000, 1);
    tbl[15] = mk(pc(5, 10'h3FF),  1, 1, 1, 3'd4, 1, 2840, 2, 20'h80000, 1);
    tbl[16] = mk('0,              0, 1, 0, 3'd0, 0, 2840, 3, 20'h00000, 0);

    for (int r = 0; r < R; r++) mb[r] = '0;
    resetn = 1'b0;
    piece_mask = '0;
    update_board_state = 1'b0;
    shift_down = 1'b0;
    add_score = 1'b0;
    score_multiplier = 3'd0;
    game_over = 1'b0;

    #12;
    check("reset board", board, '0);
    check("reset score", N'(score), '0);
    check("reset lines", N'(lines_cleared), '0);
    check("reset filled_under", N'(filled_under), '0);
    check("reset overflow", N'(overflow), '0);
    check("reset completed", N'(completed_lines), '0);
    resetn = 1'b1;
    @(posedge clock);
    #1;

    piece_mask = pc(19, 10'h00F);
    #1;
    check("bottom piece filled_under", N'(filled_under), N'(1'b1));

    for (int i = 0; i < 17; i++) begin
      drive_step($sformatf("vec%0d", i), tbl[i]);
    end

    // Board now holds row 1 col 0 and row 11 col 0 only.
    piece_mask = '0;
    #1;
    check("fu empty piece", N'(filled_under), '0);
    piece_mask = pc(10, 10'h001);
    #1;
    check("fu above cell", N'(filled_under), N'(m_fu(piece_mask)));
    check("fu above cell const", N'(filled_under), N'(1'b1));
    piece_mask = pc(10, 10'h002);
    #1;
    check("fu beside cell", N'(filled_under), N'(m_fu(piece_mask)));
    piece_mask = pc(0, 10'h001);
    #1;
    check("fu top over row1", N'(filled_under), N'(m_fu(piece_mask)));
    piece_mask = pc(18, 10'h3FF);
    #1;
    check("fu row18 over empty row19", N'(filled_under), '0);
    piece_mask = pc(19, 10'h200);
    #1;
    check("fu bottom col9", N'(filled_under), N'(1'b1));

    cur = 2840;
    for (int i = 0; i < 875; i++) begin
      cur = (cur + 1200 > 20'hFFFFF) ? 20'hFFFFF : cur + 1200;
      v = mk('0, 0, 0, 1, 3'd4, 0, cur, 3, 20'h00000, 0);
      drive_step($sformatf("sat%0d", i), v);
    end
    check("score saturated", N'(score), N'(20'hFFFFF));

    piece_mask = pc(3, 10'h001);
    update_board_state = 1'b1;
    add_score = 1'b1;
    score_multiplier = 3'd4;
    #3;
    resetn = 1'b0;
    #1;
    check("async reset board", board, '0);
    check("async reset score", N'(score), '0);
    check("async reset lines", N'(lines_cleared), '0);
    @(posedge clock);
    #1;
    check("reset aborts merge", board, '0);
    check("reset aborts score", N'(score), '0);
    check("reset fu", N'(filled_under), '0);
    check("reset overflow mid", N'(overflow), '0);
    #2;
    resetn = 1'b1;
    @(posedge clock);
    #1;
    update_board_state = 1'b0;
    add_score = 1'b0;
    check("first edge after release board", board, pc(3, 10'h001));
    check("first edge after release score", N'(score), N'(1200));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
